// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// Front-panel set-mode controller for the time-of-day counter.
//   - Debounces three raw push-buttons (mode / up / run).
//   - Mode FSM: RUN -> SET_HOUR -> SET_MIN -> SET_DAY -> RUN.
//   - Emits single-cycle increment pulses (with hold-to-auto-repeat) into the
//     counter's hour/min/day adjust inputs.
//   - Drives hold, sec_clear and blink for the counter and LCD formatter.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   btn_mode   in   raw mode button (active-high, asynchronous)
//   btn_up     in   raw increment button (active-high, asynchronous)
//   btn_run    in   raw exit button (active-high, asynchronous)
//   mode       out  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_DAY
//   inc_hour   out  one-cycle hour increment pulse
//   inc_min    out  one-cycle minute increment pulse
//   inc_day    out  one-cycle weekday increment pulse
//   hold       out  high in any SET state (freezes seconds prescaler)
//   sec_clear  out  one-cycle pulse on exit from a modified set session
//   blink      out  field blink enable; 0 in RUN
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYC = 540000,
  parameter int REPEAT_DELAY = 27000000,
  parameter int REPEAT_RATE  = 5400000,
  parameter int TIMEOUT      = 540000000,
  parameter int BLINK_HALF   = 13500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_run,
  output logic [1:0] mode,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_day,
  output logic       hold,
  output logic       sec_clear,
  output logic       blink
);

  localparam int NB      = 3;
  localparam int BTN_UP  = 1;
  localparam int RP_MAXV = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;

  localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RP_W = (RP_MAXV > 2)      ? $clog2(RP_MAXV)      : 1;
  localparam int TO_W = (TIMEOUT > 2)      ? $clog2(TIMEOUT)      : 1;
  localparam int BL_W = (BLINK_HALF > 2)   ? $clog2(BLINK_HALF)   : 1;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] RD_MAX = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RR_MAX = RP_W'(REPEAT_RATE - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF - 1);

  // ------------------------------------------------------------------------
  // Button input path: 2-flop synchroniser, stability counter, edge detect.
  // Bit order: 0=mode, 1=up, 2=run.
  // ------------------------------------------------------------------------
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_ev;
  logic          up_lvl;

  assign btn_raw = {btn_run, btn_up, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic            meta_reg;
      logic            sync_reg;
      logic            sync_last_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic            deb_reg;
      logic            deb_d_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          meta_reg      <= 1'b0;
          sync_reg      <= 1'b0;
          sync_last_reg <= 1'b0;
          db_cnt_reg    <= '0;
          deb_reg       <= 1'b0;
          deb_d_reg     <= 1'b0;
        end else begin
          meta_reg      <= btn_raw[gi];
          sync_reg      <= meta_reg;
          sync_last_reg <= sync_reg;
          deb_d_reg     <= deb_reg;
          // Any change of the synchronised level restarts the count; the
          // counter parks at its terminal value while the level is stable.
          if (sync_reg != sync_last_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg != DB_MAX) begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
          if ((sync_reg == sync_last_reg) && (db_cnt_reg == DB_MAX)) begin
            deb_reg <= sync_reg;
          end
        end
      end

      // Press event: one-cycle 0->1 transition of the debounced level.
      assign btn_ev[gi] = deb_reg & ~deb_d_reg;
    end
  endgenerate

  assign up_lvl = g_btn[BTN_UP].deb_reg;

  // ------------------------------------------------------------------------
  // Mode FSM and output generation
  // ------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_DAY  = 2'd3
  } state_t;

  state_t          state_reg,     state_next;
  logic [2:0]      inc_reg,       inc_next;      // {day, min, hour}
  logic            hold_reg,      hold_next;
  logic            sec_clear_reg, sec_clear_next;
  logic            blink_reg,     blink_next;
  logic [BL_W-1:0] bl_cnt_reg,    bl_cnt_next;
  logic            dirty_reg,     dirty_next;
  logic            rep_arm_reg,   rep_arm_next;
  logic            rep_first_reg, rep_first_next;
  logic [RP_W-1:0] rep_cnt_reg,   rep_cnt_next;
  logic [TO_W-1:0] to_cnt_reg,    to_cnt_next;

  logic ev_mode, ev_up, ev_run;
  logic in_set, timeout_hit, rep_due;
  logic enter_set, exit_set, up_pulse, up_restart;

  assign ev_mode = btn_ev[0];
  assign ev_up   = btn_ev[1];
  assign ev_run  = btn_ev[2];
  assign in_set  = (state_reg != ST_RUN);

  assign timeout_hit = in_set && (to_cnt_reg == TO_MAX);

  // First repeat waits the long delay; later ones use the short rate.
  assign rep_due = rep_arm_reg && up_lvl &&
                   (rep_first_reg ? (rep_cnt_reg == RD_MAX) : (rep_cnt_reg == RR_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RUN;
      inc_reg       <= '0;
      hold_reg      <= 1'b0;
      sec_clear_reg <= 1'b0;
      blink_reg     <= 1'b0;
      bl_cnt_reg    <= '0;
      dirty_reg     <= 1'b0;
      rep_arm_reg   <= 1'b0;
      rep_first_reg <= 1'b0;
      rep_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      inc_reg       <= inc_next;
      hold_reg      <= hold_next;
      sec_clear_reg <= sec_clear_next;
      blink_reg     <= blink_next;
      bl_cnt_reg    <= bl_cnt_next;
      dirty_reg     <= dirty_next;
      rep_arm_reg   <= rep_arm_next;
      rep_first_reg <= rep_first_next;
      rep_cnt_reg   <= rep_cnt_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    inc_next       = '0;
    sec_clear_next = 1'b0;
    dirty_next     = dirty_reg;
    // Releasing up disarms repeat immediately.
    rep_arm_next   = rep_arm_reg & up_lvl;
    rep_first_next = rep_first_reg;
    rep_cnt_next   = rep_arm_reg ? (rep_cnt_reg + 1'b1) : rep_cnt_reg;
    enter_set      = 1'b0;
    exit_set       = 1'b0;
    up_pulse       = 1'b0;
    up_restart     = 1'b0;

    // Priority: run > timeout > mode > up > auto-repeat.
    if (ev_run) begin
      exit_set = in_set;
    end else if (timeout_hit) begin
      exit_set = 1'b1;
    end else if (ev_mode) begin
      case (state_reg)
        ST_RUN:  begin state_next = ST_HOUR; enter_set = 1'b1; end
        ST_HOUR: begin state_next = ST_MIN;  enter_set = 1'b1; end
        ST_MIN:  begin state_next = ST_DAY;  enter_set = 1'b1; end
        default: exit_set = 1'b1;
      endcase
    end else if (ev_up && in_set) begin
      up_pulse       = 1'b1;
      up_restart     = 1'b1;
      rep_arm_next   = 1'b1;
      rep_first_next = 1'b1;
      rep_cnt_next   = '0;
    end else if (rep_due) begin
      up_pulse       = 1'b1;
      rep_first_next = 1'b0;
      rep_cnt_next   = '0;
    end

    if (exit_set) begin
      state_next     = ST_RUN;
      sec_clear_next = dirty_reg;
      dirty_next     = 1'b0;
      rep_arm_next   = 1'b0;
    end

    // A mode change means a held up must be released and pressed again.
    if (enter_set) begin
      rep_arm_next = 1'b0;
    end

    if (up_pulse) begin
      dirty_next = 1'b1;
      case (state_reg)
        ST_HOUR: inc_next = 3'b001;
        ST_MIN:  inc_next = 3'b010;
        ST_DAY:  inc_next = 3'b100;
        default: inc_next = 3'b000;
      endcase
    end

    // Idle timeout: repeat pulses deliberately do not count as activity.
    if ((state_next == ST_RUN) || enter_set || up_restart) begin
      to_cnt_next = '0;
    end else begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end

    // Blink: restart visible on entry and on each up press.
    if (state_next == ST_RUN) begin
      blink_next  = 1'b0;
      bl_cnt_next = '0;
    end else if (enter_set || up_restart) begin
      blink_next  = 1'b1;
      bl_cnt_next = '0;
    end else if (bl_cnt_reg == BL_MAX) begin
      blink_next  = ~blink_reg;
      bl_cnt_next = '0;
    end else begin
      blink_next  = blink_reg;
      bl_cnt_next = bl_cnt_reg + 1'b1;
    end

    hold_next = (state_next != ST_RUN);
  end

  assign mode      = state_reg;
  assign inc_hour  = inc_reg[0];
  assign inc_min   = inc_reg[1];
  assign inc_day   = inc_reg[2];
  assign hold      = hold_reg;
  assign sec_clear = sec_clear_reg;
  assign blink     = blink_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_set_ctrl
// Self-checking bench: a timestamp-based behavioural model is compared with
// the DUT on every falling edge; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_clock_set_ctrl;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int TO  = 100;
  localparam int BH  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_run = 1'b0;
  logic [1:0] mode;
  logic       inc_hour, inc_min, inc_day, hold, sec_clear, blink;

  clock_set_ctrl #(
    .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_run(btn_run), .mode(mode), .inc_hour(inc_hour), .inc_min(inc_min),
    .inc_day(inc_day), .hold(hold), .sec_clear(sec_clear), .blink(blink)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model (timestamps, not counters) ----------
  int       m_t = 0;
  bit [2:0] m_raw_d1 = '0, m_s = '0, m_deb = '0, m_deb_d = '0;
  bit [2:0] m_deb_new, m_ev;
  bit       m_up;
  int       m_chg [3] = '{-1000, -1000, -1000};
  int       m_mode = 0;
  bit       m_dirty = 1'b0, m_rep = 1'b0;
  int       m_first = 0, m_act = 0, m_blk = 0;
  bit [1:0] e_mode = '0;
  bit       e_hour = 0, e_min = 0, e_day = 0, e_hold = 0, e_sc = 0, e_blink = 0;

  task m_exit();
    e_sc    = m_dirty;
    m_dirty = 1'b0;
    m_mode  = 0;
    m_rep   = 1'b0;
  endtask

  task m_pulse();
    if (m_mode == 1) e_hour = 1'b1;
    if (m_mode == 2) e_min  = 1'b1;
    if (m_mode == 3) e_day  = 1'b1;
    m_dirty = 1'b1;
  endtask

  // Repeat schedule measured from the first pulse: RD, RD+RR, RD+2RR, ...
  function automatic bit rep_sched(input int d);
    return (d == RD) || ((d > RD) && (((d - RD) % RR) == 0));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_raw_d1 = '0; m_s = '0; m_deb = '0; m_deb_d = '0;
      for (int i = 0; i < 3; i++) m_chg[i] = m_t - 1000;
      m_mode = 0; m_dirty = 0; m_rep = 0;
      e_mode = 0; e_hour = 0; e_min = 0; e_day = 0; e_hold = 0; e_sc = 0; e_blink = 0;
    end else begin
      m_t++;
      // Debounced level follows the synchronised level once it has been
      // unchanged for DEB cycles after its last change.
      m_deb_new = m_deb;
      for (int i = 0; i < 3; i++)
        if (m_t - 1 - m_chg[i] >= DEB) m_deb_new[i] = m_s[i];
      m_ev = m_deb & ~m_deb_d;
      m_up = m_deb[1];

      e_hour = 0; e_min = 0; e_day = 0; e_sc = 0;
      m_rep = m_rep & m_up;
      if (m_ev[2]) begin
        if (m_mode != 0) m_exit();
      end else if ((m_mode != 0) && (m_t - m_act == TO)) begin
        m_exit();
      end else if (m_ev[0]) begin
        m_rep  = 1'b0;
        m_mode = (m_mode + 1) % 4;
        if (m_mode == 0) begin
          m_mode = 1; // restore so exit logic sees a SET session
          m_exit();
        end else begin
          m_act = m_t;
          m_blk = m_t;
        end
      end else if (m_ev[1] && (m_mode != 0)) begin
        m_pulse();
        m_rep   = 1'b1;
        m_first = m_t;
        m_act   = m_t;
        m_blk   = m_t;
      end else if (m_rep && rep_sched(m_t - m_first)) begin
        m_pulse();
      end

      e_mode  = 2'(m_mode);
      e_hold  = (m_mode != 0);
      e_blink = (m_mode != 0) && ((((m_t - m_blk) / BH) % 2) == 0);

      m_deb_d = m_deb;
      m_deb   = m_deb_new;
      for (int i = 0; i < 3; i++)
        if (m_raw_d1[i] != m_s[i]) m_chg[i] = m_t;
      m_s      = m_raw_d1;
      m_raw_d1 = {btn_run, btn_up, btn_mode};
    end
  end

  // ---------------- compare + monitor process ------------------------------
  int n_h = 0, n_m = 0, n_d = 0, n_sc = 0, n_sc_bad = 0;
  bit last_blink = 1'b0;
  bit rec_h = 1'b0;
  int hq[$];

  always @(negedge clk) begin
    total++;
    if (!reset) begin
      if ({mode, inc_hour, inc_min, inc_day, hold, sec_clear, blink} != 8'h00) begin
        bad++;
        $display("FAIL in_reset cyc=%0d got=%b exp=00000000", cyc,
                 {mode, inc_hour, inc_min, inc_day, hold, sec_clear, blink});
      end
    end else begin
      if ({mode, inc_hour, inc_min, inc_day, hold, sec_clear, blink} !=
          {e_mode, e_hour, e_min, e_day, e_hold, e_sc, e_blink}) begin
        bad++;
        $display("FAIL model cyc=%0d got mode=%0d ih=%0b im=%0b id=%0b hold=%0b sc=%0b bl=%0b exp mode=%0d ih=%0b im=%0b id=%0b hold=%0b sc=%0b bl=%0b",
                 cyc, mode, inc_hour, inc_min, inc_day, hold, sec_clear, blink,
                 e_mode, e_hour, e_min, e_day, e_hold, e_sc, e_blink);
      end
      if (inc_hour) n_h++;
      if (inc_min)  n_m++;
      if (inc_day)  n_d++;
      if (sec_clear) n_sc++;
      if (sec_clear && (mode != 2'd0)) n_sc_bad++;
      if (inc_hour || inc_min || inc_day) last_blink = blink;
      if (rec_h && inc_hour) hq.push_back(cyc);
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0=mode 1=up 2=run
  task automatic press(input int which, input int hold_cyc, input int gap);
    if (which == 0) btn_mode = 1'b1;
    if (which == 1) btn_up   = 1'b1;
    if (which == 2) btn_run  = 1'b1;
    tick(hold_cyc);
    btn_mode = 1'b0; btn_up = 1'b0; btn_run = 1'b0;
    tick(gap);
  endtask

  int exp_off [9] = '{0, 20, 25, 30, 35, 40, 45, 50, 55};
  int d, s_h, s_m, s_d, s_sc, t0, t1;

  initial begin
    tick(5);
    reset = 1'b1;
    tick(20);
    check("reset_mode", mode, 0);
    check("reset_hold", hold, 0);

    // 1. Bounce on btn_mode, then stable high.
    for (int i = 0; i < 6; i++) begin
      btn_mode = 1'b1; tick(2);
      btn_mode = 1'b0; tick(2);
    end
    check("bounce_no_event", mode, 0);
    btn_mode = 1'b1;
    d = 0;
    while (mode != 2'd1 && d < 50) begin @(negedge clk); d++; end
    check_rng("bounce_latency", d - 1, 6, 8);
    check("bounce_hold", hold, 1);
    tick(10); btn_mode = 1'b0; tick(10);
    check("bounce_single_event", mode, 1);

    // 2. Single increment in SET_MIN.
    press(0, 8, 8);
    check("setmin_mode", mode, 2);
    s_h = n_h; s_m = n_m; s_d = n_d;
    press(1, 10, 10);
    check("single_inc_min", n_m - s_m, 1);
    check("single_inc_hour", n_h - s_h, 0);
    check("single_inc_day", n_d - s_d, 0);
    check("single_blink", last_blink, 1);

    // Exit (dirty) then enter SET_HOUR.
    s_sc = n_sc;
    press(2, 8, 8);
    check("exit_dirty_sc", n_sc - s_sc, 1);
    check("exit_mode", mode, 0);
    press(0, 8, 8);
    check("sethour_mode", mode, 1);

    // 3. Auto-repeat: up held 60 cycles.
    hq.delete();
    rec_h = 1'b1;
    btn_up = 1'b1; tick(60);
    btn_up = 1'b0; tick(30);
    rec_h = 1'b0;
    check("repeat_count", hq.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < hq.size()) check("repeat_offset", hq[i] - hq[0], exp_off[i]);

    // 4. Exit with and without edit.
    press(2, 8, 8);
    s_sc = n_sc;
    press(0, 8, 8);
    press(1, 10, 10);
    press(2, 8, 8);
    check("edit_sc_count", n_sc - s_sc, 1);
    check("edit_sc_in_run", n_sc_bad, 0);
    check("edit_exit_mode", mode, 0);
    s_sc = n_sc;
    press(0, 8, 8);
    check("noedit_mode", mode, 1);
    press(2, 8, 8);
    check("noedit_sc_count", n_sc - s_sc, 0);

    // 5. Timeout from SET_DAY.
    press(0, 8, 8); press(0, 8, 8); press(0, 8, 8);
    check("setday_mode", mode, 3);
    s_sc = n_sc;
    btn_up = 1'b1;
    d = 0;
    while (!inc_day && d < 30) begin @(negedge clk); d++; end
    check("timeout_up_seen", inc_day, 1);
    t0 = cyc;
    tick(3); btn_up = 1'b0;
    d = 0;
    while (mode != 2'd0 && d < 200) begin @(negedge clk); d++; end
    t1 = cyc;
    check_rng("timeout_delay", t1 - t0, 99, 101);
    tick(3);
    check("timeout_sc_count", n_sc - s_sc, 1);

    // 6. Coincident mode+up, held up, then reset mid-session.
    press(0, 8, 8);
    check("conf_start_mode", mode, 1);
    s_h = n_h; s_m = n_m; s_d = n_d;
    btn_mode = 1'b1; btn_up = 1'b1;
    tick(10);
    btn_mode = 1'b0;
    tick(25);
    check("conf_mode", mode, 2);
    check("conf_no_inc", (n_h - s_h) + (n_m - s_m) + (n_d - s_d), 0);
    btn_up = 1'b0; tick(10);
    s_m = n_m;
    press(1, 10, 4);
    check("conf_inc_min", n_m - s_m, 1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("async_reset_outs", {mode, inc_hour, inc_min, inc_day, hold, sec_clear, blink}, 0);
    tick(3); reset = 1'b1; tick(3);
    check("after_reset_mode", mode, 0);
    check("after_reset_sc", sec_clear, 0);

    // Randomised phase, checked every cycle against the model.
    for (int s = 0; s < 160; s++) begin
      btn_mode = ($urandom_range(0, 3) == 0);
      btn_up   = 1'($urandom_range(0, 1));
      btn_run  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
        @(posedge clk); #3 reset = 1'b0;
        tick(2);
        reset = 1'b1;
      end
      tick($urandom_range(1, 30));
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_run = 1'b0;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Front-panel set-mode controller for the time-of-day counter block. It debounces three raw push-buttons and runs a mode FSM (RUN / SET_HOUR / SET_MIN / SET_DAY). It emits single-cycle increment pulses with hold-to-auto-repeat into the counter's hour/min/day adjust inputs. It also drives hold, sec_clear and blink for the counter and the LCD formatter.

Parameters:
DEBOUNCE_CYC, 540000, cycles a synchronised button level must stay stable before it is accepted (10 ms at 54 MHz).
REPEAT_DELAY, 27000000, cycles of continuous up-hold after the first pulse before auto-repeat starts.
REPEAT_RATE, 5400000, cycles between auto-repeat pulses.
TIMEOUT, 540000000, idle cycles in any SET state before forced return to RUN.
BLINK_HALF, 13500000, blink half-period in cycles.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_mode  in  1  raw mode button, active-high, asynchronous to clk
btn_up  in  1  raw increment button, active-high, asynchronous
btn_run  in  1  raw exit button, active-high, asynchronous; returns to RUN from any state
mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_DAY
inc_hour  out  1  one-cycle hour increment pulse
inc_min  out  1  one-cycle minute increment pulse
inc_day  out  1  one-cycle weekday increment pulse
hold  out  1  high in any SET state; counter freezes its seconds prescaler
sec_clear  out  1  one-cycle pulse that zeroes seconds and prescaler on exit from a modified set session
blink  out  1  field blink enable for the LCD; 0 in RUN

Behaviour:
- Reset (async, active-low): all outputs 0. mode=RUN. Synchronisers, debounced levels, counters and dirty flag all cleared. Reset mid-session drops straight to RUN with no sec_clear.
- Input path per button: 2-flop synchroniser, then a debounce counter that restarts on any change of the synchronised level. The debounced level takes the new value when the counter reaches DEBOUNCE_CYC-1 with the level still stable. A press event is a 0->1 transition of the debounced level, one cycle wide.
- Latency: outputs are registered. An event in cycle E updates mode and any inc_* in cycle E+1.
- FSM on mode event: RUN->SET_HOUR->SET_MIN->SET_DAY->RUN.
- FSM on run event: any SET state->RUN. In RUN the run event is ignored.
- Priority when events coincide in the same cycle: run > mode > up. Lower-priority events in that cycle are discarded.
- Up event in a SET state: exactly one pulse on the output matching mode (hour/min/day) in E+1. The dirty flag is then set.
- Up event in RUN: ignored, no pulse.
- Auto-repeat: while debounced up stays 1 and mode is unchanged, the next pulse comes REPEAT_DELAY cycles after the first. Further pulses follow every REPEAT_RATE cycles. Release stops repeat immediately.
- Any mode change disarms repeat. A held up produces no pulses in the new state until up is released and pressed again.
- At most one inc_* high in any cycle. inc_* never high in RUN.
- Idle timeout:
  - The counter clears on entering any SET state and on every mode or up event.
  - The counter does not clear while auto-repeat pulses are being produced.
  - Reaching TIMEOUT-1 forces RUN on the next cycle, exactly as a run event would.
- Exit to RUN (by mode wrap, run event or timeout): sec_clear pulses for one cycle, in the same cycle mode shows RUN, only if dirty=1. Dirty is then cleared. No sec_clear if nothing was incremented.
- hold = (mode!=RUN), registered together with mode.
- Blink:
  - On entry to any SET state, blink=1 and its counter clears.
  - blink toggles every BLINK_HALF cycles.
  - Any up event forces blink=1 and restarts the counter, so the edited field stays visible.
  - blink=0 in RUN.
- Counter widths are sized with $clog2 of their parameter. No wrap other than the explicit resets described above.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5, TIMEOUT=100, BLINK_HALF=8.
1. Bounce: btn_mode toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one mode event; mode goes 0->1 and hold=1, first at 2+4+1 cycles after the final stable edge (±1).
2. Single increment: SET_MIN, btn_up pressed 10 cycles then released -> exactly one inc_min pulse; inc_hour=inc_day=0; blink=1 on the cycle after the event.
3. Auto-repeat: SET_HOUR, btn_up held 60 debounced cycles -> inc_hour pulses at offsets 0, 20, 25, 30 … 55 relative to the first pulse (9 pulses); no pulses after release.
4. Exit with/without edit: RUN->SET_HOUR, one up, then btn_run -> mode=0 with sec_clear=1 for exactly one cycle. Repeat the session with no up -> sec_clear stays 0.
5. Timeout: enter SET_DAY, one up at entry+10, no further input -> mode returns to 0 at 100 cycles after that up event (±1 for registration), with a single sec_clear.
6. Conflicts/reset: btn_mode and btn_up debounced in the same cycle in SET_HOUR -> mode=2 and no inc pulse. Up then still held in SET_MIN -> no inc_min. Assert reset mid-SET_MIN -> mode=0, sec_clear=0, all outputs 0 asynchronously.
